// File: rtl/debug_frame_tx.sv
// debug_frame_tx: captures a DATA_WIDTH-bit debug snapshot and serialises it
// MSB-first as bytes to a UART transmitter. In framed mode each dump is wrapped
// as HEADER, LEN_HI, LEN_LO, payload..., CHK where CHK is the XOR of the length
// and payload bytes.
module debug_frame_tx #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter bit          FRAMED     = 1'b1,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_signal,
  input  logic [DATA_WIDTH-1:0] send_data,
  input  logic                  tx_busy,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic                  busy,
  output logic                  data_sent,
  output logic [15:0]           byte_index
);

  localparam int unsigned NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int unsigned SR_W   = NBYTES * 8;
  localparam int unsigned PAD    = SR_W - DATA_WIDTH;
  localparam logic [15:0] LEN    = 16'(NBYTES);
  localparam logic [15:0] LAST   = 16'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_HOLD, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    P_HDR, P_LENHI, P_LENLO, P_PAY, P_CHK
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [7:0]        cur_byte;

  // Byte selected by the current phase; payload always comes from the top of
  // the shift register.
  always_comb begin
    cur_byte = sr_q[SR_W-1 -: 8];
    case (phase_q)
      P_HDR:   cur_byte = HEADER;
      P_LENHI: cur_byte = LEN[15:8];
      P_LENLO: cur_byte = LEN[7:0];
      P_CHK:   cur_byte = chk_q;
      default: cur_byte = sr_q[SR_W-1 -: 8];
    endcase
  end

  // Outputs decoded from the state; w_data shows the live byte during the
  // strobe and the held copy otherwise, so it is stable strobe to strobe.
  assign wr_uart    = (state_q == S_SEND) && !tx_busy;
  assign w_data     = wr_uart ? cur_byte : wdat_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_SEND) ||
                      (state_q == S_HOLD) || (state_q == S_WAIT);
  assign data_sent  = (state_q == S_DONE);
  assign byte_index = idx_q;

  // State and datapath registers; reset aborts any dump in progress.
  // NOTE: the shift register is a plain flop bank, not a RAM, so clearing it
  // on reset is cheap and keeps the first dump after reset deterministic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= P_HDR;
      sr_q    <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q <= state_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
    end
  end

  // Next-state and datapath update for the byte sequencer.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    sr_d    = sr_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: if (send_signal) state_d = S_LOAD;
      S_LOAD: begin
        sr_d    = SR_W'(send_data) << PAD;   // left-align, zero LSB padding
        chk_d   = '0;
        idx_d   = '0;
        phase_d = FRAMED ? P_HDR : P_PAY;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          wdat_d = cur_byte;
          if (phase_q == P_LENHI || phase_q == P_LENLO || phase_q == P_PAY)
            chk_d = chk_q ^ cur_byte;
          state_d = S_HOLD;
        end
      end
      S_HOLD: state_d = S_WAIT;   // give the UART a cycle to raise tx_busy
      S_WAIT: begin
        if (!tx_busy) begin
          state_d = S_SEND;
          case (phase_q)
            P_HDR:   phase_d = P_LENHI;
            P_LENHI: phase_d = P_LENLO;
            P_LENLO: phase_d = P_PAY;
            P_PAY: begin
              if (idx_q == LAST) begin
                if (FRAMED) phase_d = P_CHK;
                else        state_d = S_DONE;
              end else begin
                idx_d = idx_q + 16'd1;
                sr_d  = sr_q << 8;
              end
            end
            default: state_d = S_DONE;   // checksum was the last byte
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: three instances (20-bit framed, 20-bit
// raw, 2048-bit framed) driven by a UART model that stays busy 10 cycles per
// strobe.
module tb_debug_frame_tx;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        send_sig;
  logic [2:0]        stall;
  logic [2:0]        busy_m;
  logic [2:0]        tx_busy;
  logic [2:0]        wr_uart;
  logic [2:0]        busy;
  logic [2:0]        data_sent;
  logic [7:0]        w_data     [3];
  logic [15:0]       byte_index [3];
  logic [19:0]       sd_a, sd_b;
  logic [2047:0]     sd_c;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                n_wr [3];
  int                n_done [3];
  int                first_wr [3];
  int                start_cyc [3];
  int                viol [3];
  int                busy_cnt [3];
  logic [7:0]        got [3][0:299];

  logic [7:0]        exp_a [7];
  logic [7:0]        exp_b [3];

  always #5 clk = ~clk;

  assign tx_busy = busy_m | stall;

  debug_frame_tx #(.DATA_WIDTH(20), .FRAMED(1'b1)) u_a (
    .clock(clk), .reset(rst), .send_signal(send_sig[0]), .send_data(sd_a),
    .tx_busy(tx_busy[0]), .wr_uart(wr_uart[0]), .w_data(w_data[0]),
    .busy(busy[0]), .data_sent(data_sent[0]), .byte_index(byte_index[0]));

  debug_frame_tx #(.DATA_WIDTH(20), .FRAMED(1'b0)) u_b (
    .clock(clk), .reset(rst), .send_signal(send_sig[1]), .send_data(sd_b),
    .tx_busy(tx_busy[1]), .wr_uart(wr_uart[1]), .w_data(w_data[1]),
    .busy(busy[1]), .data_sent(data_sent[1]), .byte_index(byte_index[1]));

  debug_frame_tx #(.DATA_WIDTH(2048), .FRAMED(1'b1)) u_c (
    .clock(clk), .reset(rst), .send_signal(send_sig[2]), .send_data(sd_c),
    .tx_busy(tx_busy[2]), .wr_uart(wr_uart[2]), .w_data(w_data[2]),
    .busy(busy[2]), .data_sent(data_sent[2]), .byte_index(byte_index[2]));

  // Mid-cycle monitor and UART model: log strobes and done pulses, then
  // raise tx_busy from the cycle after each strobe for 10 cycles.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (wr_uart[i]) begin
        if (n_wr[i] < 300) got[i][n_wr[i]] = w_data[i];
        n_wr[i]++;
        if (first_wr[i] < 0) first_wr[i] = cyc;
        if (tx_busy[i]) viol[i]++;
      end
      if (data_sent[i]) n_done[i]++;
      if (busy_cnt[i] > 0) begin
        busy_m[i] = 1'b1;
        busy_cnt[i]--;
      end else begin
        busy_m[i] = 1'b0;
      end
      if (wr_uart[i]) busy_cnt[i] = 10;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear(input int i);
    n_wr[i]     = 0;
    n_done[i]   = 0;
    first_wr[i] = -1;
  endtask

  task automatic start(input int i);
    @(posedge clk); #1;
    send_sig[i]  = 1'b1;
    start_cyc[i] = cyc + 1;
    @(posedge clk); #1;
    send_sig[i]  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int k = 0;
    while (n_done[i] == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_timeout"}, 32'(n_done[i] != 0), 32'd1);
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_nwr"}, n_wr[0], 7);
    for (int k = 0; k < 7; k++)
      chk($sformatf("%s_byte%0d", tag, k), got[0][k], exp_a[k]);
    chk({tag, "_ndone"}, n_done[0], 1);
    chk({tag, "_busy"}, busy[0], 0);
  endtask

  initial begin
    exp_a = '{8'hA5, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'hE0, 8'h85};
    exp_b = '{8'hAB, 8'hCD, 8'hE0};
    rst      = 1'b1;
    send_sig = '0;
    stall    = '0;
    busy_m   = '0;
    sd_a     = 20'hABCDE;
    sd_b     = 20'hABCDE;
    sd_c     = {128{16'h55AA}};
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      viol[i]     = 0;
      clear(i);
    end

    // Reset state.
    cycles(3);
    chk("rst_wr_uart", wr_uart[0], 0);
    chk("rst_w_data", w_data[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_data_sent", data_sent[0], 0);
    chk("rst_byte_index", byte_index[0], 0);
    rst = 1'b0;
    cycles(2);

    // Framed dump of 20'hABCDE.
    start(0);
    chk("a_busy_after_start", busy[0], 1);
    wait_done(0, 400, "a");
    check_a("a");
    chk("a_latency", 32'(first_wr[0] - start_cyc[0]), 2);

    // Raw dump of the same data.
    start(1);
    wait_done(1, 400, "b");
    chk("b_nwr", n_wr[1], 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b_byte%0d", k), got[1][k], exp_b[k]);
    chk("b_latency", 32'(first_wr[1] - start_cyc[1]), 2);
    chk("b_byte_index", byte_index[1], 2);

    // Data change and second request mid-dump are ignored.
    cycles(5);
    clear(0);
    start(0);
    cycles(2);
    sd_a = '1;
    send_sig[0] = 1'b1;
    cycles(1);
    send_sig[0] = 1'b0;
    wait_done(0, 400, "m");
    check_a("m");
    cycles(40);
    chk("m_no_second_nwr", n_wr[0], 7);
    chk("m_no_second_done", n_done[0], 1);
    sd_a = 20'hABCDE;

    // Reset while the CD payload byte is waiting on the UART.
    clear(0);
    start(0);
    for (int k = 0; k < 400 && n_wr[0] < 5; k++) begin
      @(negedge clk); #1;
    end
    chk("r_reached_cd", n_wr[0], 5);
    chk("r_cd_byte", got[0][4], 8'hCD);
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("r_wr_uart", wr_uart[0], 0);
    chk("r_w_data", w_data[0], 0);
    chk("r_busy", busy[0], 0);
    chk("r_data_sent", data_sent[0], 0);
    chk("r_byte_index", byte_index[0], 0);
    cycles(2);
    rst = 1'b0;
    cycles(20);
    chk("r_no_done", n_done[0], 0);
    chk("r_no_more_wr", n_wr[0], 5);
    clear(0);
    start(0);
    wait_done(0, 400, "r2");
    check_a("r2");

    // tx_busy held high before start, released after 50 cycles.
    clear(1);
    stall[1] = 1'b1;
    start(1);
    cycles(50);
    chk("s_no_wr", n_wr[1], 0);
    chk("s_busy", busy[1], 1);
    stall[1] = 1'b0;
    wait_done(1, 400, "s");
    chk("s_nwr", n_wr[1], 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("s_byte%0d", k), got[1][k], exp_b[k]);

    // 256-byte payload: length crosses into LEN_HI.
    start(2);
    wait_done(2, 8000, "c");
    chk("c_nwr", n_wr[2], 260);
    chk("c_hdr", got[2][0], 8'hA5);
    chk("c_len_hi", got[2][1], 8'h01);
    chk("c_len_lo", got[2][2], 8'h00);
    chk("c_pay0", got[2][3], 8'h55);
    chk("c_pay1", got[2][4], 8'hAA);
    chk("c_pay255", got[2][258], 8'hAA);
    chk("c_chk", got[2][259], 8'h01);
    chk("c_byte_index", byte_index[2], 255);
    chk("c_ndone", n_done[2], 1);

    for (int i = 0; i < 3; i++)
      chk($sformatf("viol%0d", i), viol[i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
